// File: rtl/sm3_pkg.sv
// Shared widths, controller state encoding and block helpers for the SM3 message front end.
package sm3_pkg;
    localparam int SM3_BLK_W         = 512;
    localparam int SM3_WORD_W        = 32;
    localparam int SM3_WORDS_PER_BLK = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_FULL,
        ST_PAD_REQ,
        ST_PAD_WAIT,
        ST_SEND_P0,
        ST_SEND_P1,
        ST_DONE
    } state_e;

    // Keep only the n most recently shifted-in words (low end), zero the rest.
    function automatic logic [SM3_BLK_W-1:0] keep_low_words(input logic [SM3_BLK_W-1:0] blk,
                                                           input logic [4:0]           n);
        logic [SM3_BLK_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < SM3_WORDS_PER_BLK; i++) begin
            if (i < int'(n)) mask[i*SM3_WORD_W +: SM3_WORD_W] = '1;
        end
        return blk & mask;
    endfunction
endpackage

// File: rtl/sm3_word_packer.sv
// Shift buffer of the current block plus word-in-block and whole-message counters.
// Total counter saturates at all-ones and raises a sticky error instead of wrapping.
module sm3_word_packer
    import sm3_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_acc,
    input  logic [SM3_WORD_W-1:0] i_word,
    input  logic                  i_wcnt_clr,
    output logic [SM3_BLK_W-1:0]  o_buf,
    output logic [4:0]            o_wcnt,
    output logic [CNT_W-1:0]      o_total,
    output logic                  o_err
);
    logic [SM3_BLK_W-1:0] msg_buf_q, msg_buf_d;
    logic [4:0]           wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic                 err_q, err_d;

    always_comb begin
        msg_buf_d = msg_buf_q;
        wcnt_d    = wcnt_q;
        total_d   = total_q;
        err_d     = err_q;
        if (i_clr) begin
            msg_buf_d = '0;
            wcnt_d    = '0;
            total_d   = '0;
            err_d     = 1'b0;
        end else if (i_acc) begin
            msg_buf_d = {msg_buf_q[SM3_BLK_W-SM3_WORD_W-1:0], i_word};
            wcnt_d    = wcnt_q + 5'd1;
            if (&total_q) err_d = 1'b1;
            else          total_d = total_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (i_wcnt_clr) begin
            wcnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            msg_buf_q <= '0;
            wcnt_q    <= '0;
            total_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            msg_buf_q <= msg_buf_d;
            wcnt_q    <= wcnt_d;
            total_q   <= total_d;
            err_q     <= err_d;
        end
    end

    assign o_buf   = msg_buf_q;
    assign o_wcnt  = wcnt_q;
    assign o_total = total_q;
    assign o_err   = err_q;
endmodule

// File: rtl/sm3_msg_ctrl.sv
// SM3 front end: packs words into blocks, issues full blocks, hands the tail to the padding unit.
// Word-to-block and last-word-to-pad-start are both one cycle; output blocks hold while the core stalls.
module sm3_msg_ctrl
    import sm3_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SM3_WORD_W-1:0] i_word,
    input  logic                  i_word_valid,
    input  logic                  i_word_last,
    output logic                  o_word_ready,
    output logic [SM3_BLK_W-1:0]  o_pad_data,
    output logic [9:0]            o_pad_len,
    output logic                  o_pad_mlflag,
    output logic [CNT_W-1:0]      o_pad_total,
    output logic                  o_pad_valid,
    input  logic [SM3_BLK_W-1:0]  i_padded0,
    input  logic [SM3_BLK_W-1:0]  i_padded1,
    input  logic                  i_pad_done,
    input  logic                  i_pad_done1,
    output logic [SM3_BLK_W-1:0]  o_blk_data,
    output logic                  o_blk_valid,
    input  logic                  i_blk_ready,
    output logic                  o_blk_last,
    output logic                  o_msg_done,
    output logic                  o_busy,
    output logic                  o_err
);
    state_e               state_q, state_d;
    logic                 last_q, last_d;
    logic                 mlflag_q, mlflag_d;
    logic                 done1_q, done1_d;
    logic [SM3_BLK_W-1:0] cap0_q, cap0_d;
    logic [SM3_BLK_W-1:0] cap1_q, cap1_d;

    logic                 pk_clr, pk_acc, pk_wcnt_clr;
    logic [SM3_BLK_W-1:0] pk_buf;
    logic [4:0]           pk_wcnt;
    logic [CNT_W-1:0]     pk_total;
    logic                 pk_err;

    sm3_word_packer #(.CNT_W(CNT_W)) u_packer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (pk_clr),
        .i_acc      (pk_acc),
        .i_word     (i_word),
        .i_wcnt_clr (pk_wcnt_clr),
        .o_buf      (pk_buf),
        .o_wcnt     (pk_wcnt),
        .o_total    (pk_total),
        .o_err      (pk_err)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mlflag_d    = mlflag_q;
        done1_d     = done1_q;
        cap0_d      = cap0_q;
        cap1_d      = cap1_q;
        pk_clr      = 1'b0;
        pk_acc      = 1'b0;
        pk_wcnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    pk_clr   = 1'b1;
                    mlflag_d = 1'b0;
                    last_d   = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (i_word_valid) begin
                    pk_acc = 1'b1;
                    if (pk_wcnt == 5'(SM3_WORDS_PER_BLK - 1)) begin
                        last_d  = i_word_last;
                        state_d = ST_SEND_FULL;
                    end else if (i_word_last) begin
                        state_d = ST_PAD_REQ;
                    end
                end
            end
            ST_SEND_FULL: begin
                if (i_blk_ready) begin
                    mlflag_d    = 1'b1;
                    pk_wcnt_clr = 1'b1;
                    state_d     = last_q ? ST_PAD_REQ : ST_COLLECT;
                end
            end
            ST_PAD_REQ: state_d = ST_PAD_WAIT;
            ST_PAD_WAIT: begin
                // The padding unit drops its result next cycle, so capture right here.
                if (i_pad_done) begin
                    cap0_d  = i_padded0;
                    cap1_d  = i_padded1;
                    done1_d = i_pad_done1;
                    state_d = ST_SEND_P0;
                end
            end
            ST_SEND_P0: begin
                if (i_blk_ready) state_d = done1_q ? ST_SEND_P1 : ST_DONE;
            end
            ST_SEND_P1: begin
                if (i_blk_ready) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b0;
            mlflag_q <= 1'b0;
            done1_q  <= 1'b0;
            cap0_q   <= '0;
            cap1_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            mlflag_q <= mlflag_d;
            done1_q  <= done1_d;
            cap0_q   <= cap0_d;
            cap1_q   <= cap1_d;
        end
    end

    // Block outputs are pure decodes of flops, so they cannot move during a stall.
    always_comb begin
        o_blk_data = '0;
        o_blk_last = 1'b0;
        case (state_q)
            ST_SEND_FULL: o_blk_data = pk_buf;
            ST_SEND_P0: begin
                o_blk_data = cap0_q;
                o_blk_last = !done1_q;
            end
            ST_SEND_P1: begin
                o_blk_data = cap1_q;
                o_blk_last = 1'b1;
            end
            default: o_blk_data = '0;
        endcase
    end

    assign o_word_ready = (state_q == ST_COLLECT);
    assign o_blk_valid  = (state_q == ST_SEND_FULL) || (state_q == ST_SEND_P0) ||
                          (state_q == ST_SEND_P1);
    assign o_pad_valid  = (state_q == ST_PAD_REQ);
    assign o_msg_done   = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_err        = pk_err;

    // Packer state is frozen from PAD_REQ until the next start, which keeps these stable.
    assign o_pad_data   = keep_low_words(pk_buf, pk_wcnt);
    assign o_pad_len    = {5'd0, pk_wcnt};
    assign o_pad_mlflag = mlflag_q;
    assign o_pad_total  = pk_total;
endmodule

// File: tb/tb_sm3_msg_ctrl.sv
// Bench for sm3_msg_ctrl: table of message cases plus random messages against a block-list model.
module tb_sm3_msg_ctrl;
    localparam int CNT_W = 5;
    localparam int TMAX  = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [31:0]       i_word;
    logic              i_word_valid;
    logic              i_word_last;
    logic              o_word_ready;
    logic [511:0]      o_pad_data;
    logic [9:0]        o_pad_len;
    logic              o_pad_mlflag;
    logic [CNT_W-1:0]  o_pad_total;
    logic              o_pad_valid;
    logic [511:0]      i_padded0;
    logic [511:0]      i_padded1;
    logic              i_pad_done;
    logic              i_pad_done1;
    logic [511:0]      o_blk_data;
    logic              o_blk_valid;
    logic              i_blk_ready;
    logic              o_blk_last;
    logic              o_msg_done;
    logic              o_busy;
    logic              o_err;

    sm3_msg_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .i_word_last  (i_word_last),
        .o_word_ready (o_word_ready),
        .o_pad_data   (o_pad_data),
        .o_pad_len    (o_pad_len),
        .o_pad_mlflag (o_pad_mlflag),
        .o_pad_total  (o_pad_total),
        .o_pad_valid  (o_pad_valid),
        .i_padded0    (i_padded0),
        .i_padded1    (i_padded1),
        .i_pad_done   (i_pad_done),
        .i_pad_done1  (i_pad_done1),
        .o_blk_data   (o_blk_data),
        .o_blk_valid  (o_blk_valid),
        .i_blk_ready  (i_blk_ready),
        .o_blk_last   (o_blk_last),
        .o_msg_done   (o_msg_done),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int vec_cnt;
    int err_cnt;

    typedef struct {
        int          n;
        logic [31:0] w0;
        int          stall;
        int          len;
        bit          ml;
        int          tot;
        bit          err;
        int          nblk;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, {o_word_ready, o_pad_valid, o_blk_valid, o_blk_last, o_msg_done,
                            o_busy, o_err, o_pad_mlflag, o_pad_len, o_pad_total}, '0);
        chk({tag, "_pad_dat"}, o_pad_data, '0);
        chk({tag, "_blk_dat"}, o_blk_data, '0);
    endtask

    // Runs one message; the expected block list comes from the message words alone.
    task automatic run_msg(input int n, input bit rnd, input logic [31:0] w0, input int stall,
                           output int r_len, output bit r_ml, output int r_tot,
                           output bit r_err, output int r_nblk);
        logic [31:0]  w[$];
        logic [511:0] exp_blk[$];
        bit           exp_last[$];
        logic [511:0] blk, p0, p1, exp_pad;
        bit           d1, done_seen;
        int           full, rem, widx, bidx, pad_cnt, pad_wait, stall_ctr, exp_tot;

        w.delete(); exp_blk.delete(); exp_last.delete();
        for (int i = 0; i < n; i++) w.push_back(rnd ? 32'($urandom) : w0 + 32'(i));
        full = n / 16;
        rem  = n % 16;
        for (int j = 0; j < full; j++) begin
            blk = '0;
            for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = w[16*j + i];
            exp_blk.push_back(blk);
            exp_last.push_back(1'b0);
        end
        d1 = (rem >= 14);
        p0 = rnd512();
        p1 = rnd512();
        exp_blk.push_back(p0);
        exp_last.push_back(!d1);
        if (d1) begin
            exp_blk.push_back(p1);
            exp_last.push_back(1'b1);
        end
        exp_pad = '0;
        for (int i = 0; i < rem; i++) exp_pad[(rem - 1 - i)*32 +: 32] = w[16*full + i];
        exp_tot = (n > TMAX) ? TMAX : n;
        r_len = -1; r_ml = 0; r_tot = -1;

        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        chk("start_err_clr", o_err, 0);
        chk("start_busy", o_busy, 1);

        widx = 0; bidx = 0; pad_cnt = 0; pad_wait = -1; stall_ctr = stall; done_seen = 0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            i_pad_done  = 1'b0;
            i_pad_done1 = 1'($urandom);
            i_padded0   = rnd512();
            i_padded1   = rnd512();
            if (pad_wait == 0) begin
                i_pad_done  = 1'b1;
                i_padded0   = p0;
                i_padded1   = p1;
                i_pad_done1 = d1;
            end
            if (pad_wait >= 0) pad_wait--;

            if (widx < n && (!rnd || $urandom_range(0, 3) != 0)) begin
                i_word_valid = 1'b1;
                i_word       = w[widx];
                i_word_last  = (widx == n - 1);
            end else begin
                i_word_valid = 1'b0;
                i_word       = $urandom;
                i_word_last  = 1'($urandom);
            end
            if (i_word_valid && o_word_ready) widx++;

            if (o_blk_valid) begin
                chk("word_rdy_in_send", o_word_ready, 0);
                if (bidx < exp_blk.size()) begin
                    chk("blk_dat", o_blk_data, exp_blk[bidx]);
                    chk("blk_last", o_blk_last, exp_last[bidx]);
                end else begin
                    chk("blk_count", bidx, exp_blk.size() - 1);
                end
                if (rnd) begin
                    i_blk_ready = 1'($urandom_range(0, 1));
                end else begin
                    i_blk_ready = (stall_ctr == 0);
                    if (stall_ctr > 0) stall_ctr--;
                end
                if (i_blk_ready) begin
                    bidx++;
                    stall_ctr = stall;
                end
            end else begin
                i_blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end

            if (o_pad_valid) begin
                pad_cnt++;
                chk("pad_len", o_pad_len, rem);
                chk("pad_dat", o_pad_data, exp_pad);
                chk("pad_ml", o_pad_mlflag, full > 0);
                chk("pad_tot", o_pad_total, exp_tot);
                r_len = int'(o_pad_len); r_ml = o_pad_mlflag; r_tot = int'(o_pad_total);
                pad_wait = $urandom_range(0, 3);
            end
            if (o_msg_done) begin
                chk("done_after_last", bidx, exp_blk.size());
                done_seen = 1'b1;
            end
            @(negedge i_clk);
        end
        i_word_valid = 1'b0; i_blk_ready = 1'b0; i_pad_done = 1'b0; i_word_last = 1'b0;
        chk("msg_done_seen", done_seen, 1);
        chk("pad_pulses", pad_cnt, 1);
        chk("words_taken", widx, n);
        chk("idle_busy", o_busy, 0);
        chk("pad_len_hold", o_pad_len, rem);
        chk("pad_dat_hold", o_pad_data, exp_pad);
        chk("err_flag", o_err, n > TMAX);
        r_err  = o_err;
        r_nblk = bidx;
    endtask

    initial begin
        int len, tot, nb;
        bit ml, e;
        bit seen;

        vec_cnt = 0; err_cnt = 0;
        i_rst = 1'b1; i_start = 1'b0; i_word = '0; i_word_valid = 1'b0; i_word_last = 1'b0;
        i_padded0 = '0; i_padded1 = '0; i_pad_done = 1'b0; i_pad_done1 = 1'b0; i_blk_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_idle("in_rst");
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_idle("post_rst");

        tbl[0] = '{n: 1,  w0: 32'h61626364, stall: 0, len: 1,  ml: 0, tot: 1,  err: 0, nblk: 1};
        tbl[1] = '{n: 14, w0: 32'h00010000, stall: 0, len: 14, ml: 0, tot: 14, err: 0, nblk: 2};
        tbl[2] = '{n: 16, w0: 32'hA0000000, stall: 0, len: 0,  ml: 1, tot: 16, err: 0, nblk: 2};
        tbl[3] = '{n: 17, w0: 32'h11110000, stall: 5, len: 1,  ml: 1, tot: 17, err: 0, nblk: 2};
        tbl[4] = '{n: 15, w0: 32'h22220000, stall: 1, len: 15, ml: 0, tot: 15, err: 0, nblk: 2};
        tbl[5] = '{n: 30, w0: 32'h33330000, stall: 2, len: 14, ml: 1, tot: 30, err: 0, nblk: 3};
        tbl[6] = '{n: 33, w0: 32'h44440000, stall: 0, len: 1,  ml: 1, tot: TMAX, err: 1, nblk: 3};

        for (int t = 0; t < 7; t++) begin
            run_msg(tbl[t].n, 1'b0, tbl[t].w0, tbl[t].stall, len, ml, tot, e, nb);
            chk("tbl_len", len, tbl[t].len);
            chk("tbl_ml", ml, tbl[t].ml);
            chk("tbl_tot", tot, tbl[t].tot);
            chk("tbl_err", e, tbl[t].err);
            chk("tbl_nblk", nb, tbl[t].nblk);
            if (tbl[t].err) begin
                repeat (3) @(negedge i_clk);
                chk("err_sticky", o_err, 1);
            end
        end

        // Reset while the padding unit is still working on a 3-word message.
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_word_valid = 1'b1;
            i_word       = 32'hC0DE0000 + 32'(k);
            i_word_last  = (k == 2);
            @(negedge i_clk);
        end
        i_word_valid = 1'b0; i_word_last = 1'b0;
        chk("pad_start_latency", o_pad_valid, 1);
        repeat (2) @(negedge i_clk);
        chk("pad_wait_busy", o_busy, 1);
        i_rst = 1'b1;
        #1;
        chk_idle("mid_rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        i_pad_done = 1'b1; i_pad_done1 = 1'b1; i_padded0 = rnd512(); i_padded1 = rnd512();
        @(negedge i_clk);
        i_pad_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_blk_valid || o_busy || o_msg_done) seen = 1'b1;
            @(negedge i_clk);
        end
        chk("stale_pad_ignored", seen, 0);
        run_msg(2, 1'b0, 32'h0BAD0000, 0, len, ml, tot, e, nb);
        chk("after_rst_len", len, 2);
        chk("after_rst_tot", tot, 2);
        chk("after_rst_nblk", nb, 1);

        for (int r = 0; r < 30; r++) begin
            run_msg($urandom_range(1, 40), 1'b1, 32'h0, 0, len, ml, tot, e, nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/sm3_msg_ctrl.md
Name: sm3_msg_ctrl

Overview:
- Front-end sequencer for the SM3 hash core. Accepts a message as a stream of 32-bit words and packs them into 512-bit blocks.
- Full blocks go straight to the compression core.
- The final partial block, plus the running word count, goes to the sm3_padding unit. The controller then captures the one or two padded blocks the padding unit returns and forwards them to the compression core.
- Owns the padding unit's single-shot start protocol, so the padding unit never sees back-pressure.

Parameters:
- CNT_W, 32, width of the total-message word counter. It drives the padding unit's multi-block length input.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_start  in  1  pulse; begin a new message (honoured only in IDLE)
- i_word  in  32  message word, big-endian, first word most significant
- i_word_valid  in  1  word present
- i_word_last  in  1  qualifies i_word as the final word of the message
- o_word_ready  out  1  word accepted when valid&ready
- o_pad_data  out  512  partial block, right-aligned: valid words in the low bits, first word highest
- o_pad_len  out  10  valid words in o_pad_data, 0..15
- o_pad_mlflag  out  1  1 if at least one full block was already issued for this message
- o_pad_total  out  CNT_W  total message words
- o_pad_valid  out  1  one-cycle start pulse to the padding unit
- i_padded0  in  512  first padded block
- i_padded1  in  512  second padded block
- i_pad_done  in  1  padded result valid; this cycle only
- i_pad_done1  in  1  second block present; qualified by i_pad_done
- o_blk_data  out  512  block to the compression core
- o_blk_valid  out  1  block present
- i_blk_ready  in  1  compression core accepts
- o_blk_last  out  1  marks the final block of the message
- o_msg_done  out  1  one-cycle pulse after the last block is accepted
- o_busy  out  1  high in every state except IDLE
- o_err  out  1  sticky word-counter overflow; cleared by i_start

Behaviour:
- Reset: state=IDLE. All outputs are 0, including buffers, counters and o_err.
- States: IDLE, COLLECT, SEND_FULL, PAD_REQ, PAD_WAIT, SEND_P0, SEND_P1, DONE.
- IDLE: on i_start, clear the word buffer, word-in-block count (wcnt), total count, mlflag and o_err, then go to COLLECT. i_start in any other state is ignored.
- COLLECT:
  - o_word_ready=1.
  - On accept: buf <= {buf[479:0], i_word}; wcnt++; total++.
  - If total would wrap past 2^CNT_W-1, set o_err and hold total.
  - Accept with wcnt reaching 16 → SEND_FULL, remembering i_word_last.
  - Accept of a last word with wcnt<16 → PAD_REQ.
- SEND_FULL:
  - o_word_ready=0; o_blk_data=buf; o_blk_valid=1; o_blk_last=0.
  - On i_blk_ready: set mlflag, wcnt=0.
  - Next state is PAD_REQ if the remembered last flag is set, else COLLECT.
  - A 16-word-aligned message therefore gets an empty pad block (o_pad_len=0).
- PAD_REQ:
  - Drive o_pad_data=buf with words above wcnt zeroed, o_pad_len=wcnt, o_pad_mlflag=mlflag, o_pad_total=total.
  - o_pad_valid=1 for exactly one cycle, then PAD_WAIT.
  - The o_pad_* data outputs hold stable until the next i_start.
- PAD_WAIT:
  - On i_pad_done, capture i_padded0, i_padded1 and i_pad_done1 in that same cycle. The padding unit clears its result on the following cycle, so capture must not be delayed.
  - Then go to SEND_P0.
  - No timeout; reset is the only exit.
- SEND_P0:
  - o_blk_data=captured block 0; o_blk_last = !done1.
  - On i_blk_ready: go to SEND_P1 if done1, else DONE.
- SEND_P1: o_blk_data=captured block 1; o_blk_last=1. On i_blk_ready → DONE.
- DONE: o_msg_done=1 for one cycle → IDLE.
- Handshake rules:
  - o_blk_valid and o_blk_data must not change while valid&!ready.
  - Word transfer is valid&ready; no combinational path from i_blk_ready to o_word_ready.
- Latency:
  - Word to full-block valid: 1 cycle after the 16th accept.
  - Last word to o_pad_valid: 1 cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any in-flight padding result is discarded.

Decomposition:
- Package sm3_pkg: state enum, SM3_BLK_W=512, SM3_WORD_W=32, SM3_WORDS_PER_BLK=16.
- One natural sub-module: sm3_word_packer (shift buffer, wcnt, total, overflow), instantiated in the controller.
- The padding unit is instantiated beside this block, not inside it.

Test Plan:
- 1 word 0x61626364, last → o_pad_len=1, mlflag=0, total=1; stub returns done1=0 → one block with o_blk_last=1, then o_msg_done.
- 14 words → o_pad_len=14 (448 bits); stub returns done1=1 → two blocks; block0 last=0, block1 last=1.
- 16 words, last on word 16 → one full block with data equal to words in order at [511:480]..[31:0], last=0; then o_pad_len=0, mlflag=1, total=16.
- 17 words with i_blk_ready held low 5 cycles on each block → data stable while stalled; o_word_ready=0 during SEND_FULL; o_pad_len=1, total=17.
- Assert i_rst during PAD_WAIT, then a 2-word message → first message produces no outputs; second gives o_pad_len=2, total=2.
- Force total to 2^CNT_W-1 and push one more word → o_err=1 and held until the next i_start.
